// File: rtl/ysyx_25040101_srcb_stage.sv
// ALU operand-B source select with rs2 forwarding, registered behind a
// 2-entry valid/ready skid buffer (main register M drives the outputs, S absorbs back-pressure).
module ysyx_25040101_srcb_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NR_FWD  = 2,
  parameter int unsigned PC_INC  = 4,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [4:0]               srcb_ctrl_i,
  input  logic [4:0]               rs2_addr_i,
  input  logic [XLEN-1:0]          rs2_data_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [XLEN-1:0]          csr_data_i,
  input  logic [NR_FWD-1:0]        fwd_valid_i,
  input  logic [5*NR_FWD-1:0]      fwd_addr_i,
  input  logic [XLEN*NR_FWD-1:0]   fwd_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          srcb_data_o,
  output logic                     illegal_o
);

  logic            m_valid_q, m_valid_d;
  logic [XLEN-1:0] m_data_q, m_data_d;
  logic            m_ill_q, m_ill_d;
  logic            s_valid_q, s_valid_d;
  logic [XLEN-1:0] s_data_q, s_data_d;
  logic            s_ill_q, s_ill_d;

  logic [XLEN-1:0] rs2v;
  logic            fwd_hit;
  logic [XLEN-1:0] sel_data;
  logic            sel_ill;
  logic            accept;
  logic            fire;

  // Effective rs2: lowest-index matching forwarder wins; x0 always reads zero.
  always_comb begin
    rs2v    = rs2_data_i;
    fwd_hit = 1'b0;
    for (int k = 0; k < int'(NR_FWD); k++) begin
      if (!fwd_hit && fwd_valid_i[k] && (fwd_addr_i[5*k +: 5] == rs2_addr_i)) begin
        rs2v    = fwd_data_i[XLEN*k +: XLEN];
        fwd_hit = 1'b1;
      end
    end
    if (rs2_addr_i == 5'd0) begin
      rs2v = '0;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_ill  = 1'b0;
    case (srcb_ctrl_i)
      5'b00000: sel_data = rs2v;
      5'b00001: sel_data = imm_i;
      5'b00010: sel_data = XLEN'(PC_INC);
      5'b00100: sel_data = XLEN'(rs2v[SHAMT_W-1:0]);
      5'b01000: sel_data = csr_data_i;
      5'b10000: sel_data = '0;
      default:  sel_ill  = 1'b1;
    endcase
  end

  assign in_ready_o  = ~s_valid_q;
  assign accept      = in_valid_i & ~s_valid_q & ~flush_i;
  assign fire        = m_valid_q & out_ready_i;
  assign out_valid_o = m_valid_q;
  assign srcb_data_o = m_data_q;
  assign illegal_o   = m_ill_q;

  // Skid-buffer next state; flush dominates everything else.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ill_d   = m_ill_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ill_d   = s_ill_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (fire) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ill_d   = s_ill_q;
        s_valid_d = 1'b0;
      end
    end else if (!m_valid_q || fire) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = sel_data;
        m_ill_d   = sel_ill;
      end else if (fire) begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = sel_data;
      s_ill_d   = sel_ill;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ill_q   <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ill_q   <= m_ill_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Skid payload is only observed behind s_valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    s_data_q <= s_data_d;
    s_ill_q  <= s_ill_d;
  end

endmodule

// File: tb/tb_ysyx_25040101_srcb_stage.sv
// Directed self-checking bench for ysyx_25040101_srcb_stage (32-bit and 64-bit instances).
module tb_ysyx_25040101_srcb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_i, in_valid_i, out_ready_i;
  logic [4:0]  srcb_ctrl_i, rs2_addr_i;
  logic [31:0] rs2_data_i, imm_i, csr_data_i;
  logic [1:0]  fwd_valid_i;
  logic [9:0]  fwd_addr_i;
  logic [63:0] fwd_data_i;
  logic        in_ready_o, out_valid_o, illegal_o;
  logic [31:0] srcb_data_o;

  logic        w_flush, w_in_valid, w_out_ready;
  logic [4:0]  w_ctrl, w_rs2_addr;
  logic [63:0] w_rs2_data, w_imm, w_csr;
  logic [1:0]  w_fwd_valid;
  logic [9:0]  w_fwd_addr;
  logic [127:0] w_fwd_data;
  logic        w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_srcb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ysyx_25040101_srcb_stage #(.XLEN(32), .NR_FWD(2), .PC_INC(4), .SHAMT_W(5)) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .srcb_ctrl_i(srcb_ctrl_i), .rs2_addr_i(rs2_addr_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .csr_data_i(csr_data_i),
    .fwd_valid_i(fwd_valid_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .srcb_data_o(srcb_data_o),
    .illegal_o(illegal_o)
  );

  ysyx_25040101_srcb_stage #(.XLEN(64), .NR_FWD(2), .PC_INC(4), .SHAMT_W(6)) dut64 (
    .clock(clock), .reset(reset), .flush_i(w_flush), .in_valid_i(w_in_valid),
    .in_ready_o(w_in_ready), .srcb_ctrl_i(w_ctrl), .rs2_addr_i(w_rs2_addr),
    .rs2_data_i(w_rs2_data), .imm_i(w_imm), .csr_data_i(w_csr),
    .fwd_valid_i(w_fwd_valid), .fwd_addr_i(w_fwd_addr), .fwd_data_i(w_fwd_data),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready), .srcb_data_o(w_srcb),
    .illegal_o(w_illegal)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush_i = 0; in_valid_i = 0; out_ready_i = 0; srcb_ctrl_i = 0; rs2_addr_i = 0;
    rs2_data_i = 0; imm_i = 0; csr_data_i = 0; fwd_valid_i = 0; fwd_addr_i = 0; fwd_data_i = 0;
    w_flush = 0; w_in_valid = 0; w_out_ready = 0; w_ctrl = 0; w_rs2_addr = 0;
    w_rs2_data = 0; w_imm = 0; w_csr = 0; w_fwd_valid = 0; w_fwd_addr = 0; w_fwd_data = 0;
    step(); step();
    vectors++;
    if ({out_valid_o, srcb_data_o, illegal_o} !== 34'd0) begin
      $display("FAIL reset_outputs: got v=%b d=%h i=%b want 0/0/0", out_valid_o, srcb_data_o, illegal_o);
      miscompares++;
    end
    reset = 1'b0;
    step();
    vectors++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      $display("FAIL reset_ready: got rdy=%b v=%b want 1/0", in_ready_o, out_valid_o);
      miscompares++;
    end
  endtask

  task automatic test_sources();
    logic [4:0]  codes [6] = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    logic [31:0] exps  [6] = '{32'h12345687, 32'hFFFFF800, 32'h4, 32'h7, 32'hA5A5A5A5, 32'h0};
    out_ready_i = 1; in_valid_i = 1; rs2_addr_i = 5'd3;
    rs2_data_i = 32'h12345687; imm_i = 32'hFFFFF800; csr_data_i = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) begin
      srcb_ctrl_i = codes[i];
      step();
      vectors++;
      if (out_valid_o !== 1'b1 || srcb_data_o !== exps[i] || illegal_o !== 1'b0) begin
        $display("FAIL source_%b: got v=%b d=%h i=%b want 1/%h/0", codes[i], out_valid_o, srcb_data_o, illegal_o, exps[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_forwarding();
    rs2_addr_i = 5'd5; rs2_data_i = 32'h1; srcb_ctrl_i = 5'b00000;
    fwd_valid_i = 2'b11; fwd_addr_i = {5'd5, 5'd5}; fwd_data_i = {32'hBB, 32'hAA};
    step();
    vectors++;
    if (srcb_data_o !== 32'hAA) begin
      $display("FAIL fwd_priority: got %h want 000000aa", srcb_data_o); miscompares++;
    end
    fwd_valid_i = 2'b10;
    step();
    vectors++;
    if (srcb_data_o !== 32'hBB) begin
      $display("FAIL fwd_second: got %h want 000000bb", srcb_data_o); miscompares++;
    end
    fwd_valid_i = 2'b11; fwd_addr_i = 10'd0; rs2_addr_i = 5'd0; rs2_data_i = 32'h55;
    step();
    vectors++;
    if (srcb_data_o !== 32'h0) begin
      $display("FAIL fwd_x0: got %h want 00000000", srcb_data_o); miscompares++;
    end
    rs2_addr_i = 5'd5; rs2_data_i = 32'h1; srcb_ctrl_i = 5'b00100;
    fwd_valid_i = 2'b01; fwd_addr_i = {5'd0, 5'd5}; fwd_data_i = {32'h0, 32'h3F};
    step();
    vectors++;
    if (srcb_data_o !== 32'h1F) begin
      $display("FAIL fwd_shamt: got %h want 0000001f", srcb_data_o); miscompares++;
    end
    fwd_valid_i = 2'b00; in_valid_i = 0;
    step();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      $display("FAIL drain_idle: got v=%b want 0", out_valid_o); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 0; in_valid_i = 1; srcb_ctrl_i = 5'b00001; imm_i = 32'd1;
    step();
    vectors++;
    if (out_valid_o !== 1'b1 || srcb_data_o !== 32'd1 || in_ready_o !== 1'b1) begin
      $display("FAIL bp_a_in_m: got v=%b d=%h rdy=%b want 1/1/1", out_valid_o, srcb_data_o, in_ready_o); miscompares++;
    end
    imm_i = 32'd2;
    step();
    vectors++;
    if (out_valid_o !== 1'b1 || srcb_data_o !== 32'd1 || in_ready_o !== 1'b0) begin
      $display("FAIL bp_b_in_s: got v=%b d=%h rdy=%b want 1/1/0", out_valid_o, srcb_data_o, in_ready_o); miscompares++;
    end
    in_valid_i = 0; imm_i = 32'd9;
    step();
    vectors++;
    if (srcb_data_o !== 32'd1 || in_ready_o !== 1'b0) begin
      $display("FAIL bp_hold: got d=%h rdy=%b want 1/0", srcb_data_o, in_ready_o); miscompares++;
    end
    out_ready_i = 1;
    step();
    vectors++;
    if (out_valid_o !== 1'b1 || srcb_data_o !== 32'd2 || in_ready_o !== 1'b1) begin
      $display("FAIL bp_drain_b: got v=%b d=%h rdy=%b want 1/2/1", out_valid_o, srcb_data_o, in_ready_o); miscompares++;
    end
    step();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      $display("FAIL bp_empty: got v=%b want 0", out_valid_o); miscompares++;
    end
  endtask

  task automatic test_flush();
    out_ready_i = 0; in_valid_i = 1; srcb_ctrl_i = 5'b00001;
    imm_i = 32'h11; step();
    imm_i = 32'h22; step();
    imm_i = 32'h33; flush_i = 1;
    step();
    vectors++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      $display("FAIL flush_full: got v=%b rdy=%b want 0/1", out_valid_o, in_ready_o); miscompares++;
    end
    flush_i = 0; imm_i = 32'h44;
    step();
    imm_i = 32'h55; flush_i = 1;
    step();
    flush_i = 0; in_valid_i = 0; out_ready_i = 1;
    vectors++;
    if (out_valid_o !== 1'b0) begin
      $display("FAIL flush_drop: got v=%b d=%h want v=0", out_valid_o, srcb_data_o); miscompares++;
    end
    step();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      $display("FAIL flush_after: got v=%b d=%h want v=0", out_valid_o, srcb_data_o); miscompares++;
    end
  endtask

  task automatic test_illegal();
    out_ready_i = 1; in_valid_i = 1; srcb_ctrl_i = 5'b00011; imm_i = 32'h99;
    step();
    vectors++;
    if (out_valid_o !== 1'b1 || srcb_data_o !== 32'h0 || illegal_o !== 1'b1) begin
      $display("FAIL illegal_set: got v=%b d=%h i=%b want 1/0/1", out_valid_o, srcb_data_o, illegal_o); miscompares++;
    end
    srcb_ctrl_i = 5'b00001;
    step();
    vectors++;
    if (srcb_data_o !== 32'h99 || illegal_o !== 1'b0) begin
      $display("FAIL illegal_clear: got d=%h i=%b want 99/0", srcb_data_o, illegal_o); miscompares++;
    end
    in_valid_i = 0;
    step();
  endtask

  task automatic test_async_reset();
    out_ready_i = 0; in_valid_i = 1; srcb_ctrl_i = 5'b00011;
    step();
    srcb_ctrl_i = 5'b00001; imm_i = 32'h88;
    step();
    in_valid_i = 0;
    vectors++;
    if (illegal_o !== 1'b1 || in_ready_o !== 1'b0) begin
      $display("FAIL areset_pre: got i=%b rdy=%b want 1/0", illegal_o, in_ready_o); miscompares++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (out_valid_o !== 1'b0 || srcb_data_o !== 32'h0 || illegal_o !== 1'b0) begin
      $display("FAIL areset_now: got v=%b d=%h i=%b want 0/0/0", out_valid_o, srcb_data_o, illegal_o); miscompares++;
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      $display("FAIL areset_post: got rdy=%b v=%b want 1/0", in_ready_o, out_valid_o); miscompares++;
    end
  endtask

  task automatic test_xlen64();
    w_out_ready = 1; w_in_valid = 1; w_ctrl = 5'b00100; w_rs2_addr = 5'd3; w_rs2_data = 64'hFF;
    step();
    vectors++;
    if (w_out_valid !== 1'b1 || w_srcb !== 64'h3F) begin
      $display("FAIL x64_shamt: got v=%b d=%h want 1/3f", w_out_valid, w_srcb); miscompares++;
    end
    w_ctrl = 5'b00001; w_imm = 64'hFFFF_FFFF_0000_0001;
    step();
    vectors++;
    if (w_srcb !== 64'hFFFF_FFFF_0000_0001) begin
      $display("FAIL x64_imm: got %h want ffffffff00000001", w_srcb); miscompares++;
    end
    w_in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_sources();
    test_forwarding();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_async_reset();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
